// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer that time-shares one external 1-bit full adder.
// Operands are consumed LSB first; the result, carry-out and signed overflow are registered.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             sub_r;
  logic             carry_r;
  logic [CW-1:0]    cnt;
  logic             running;

  // Adder inputs come only from registers and stay quiet outside RUN.
  assign running = (state == RUN);
  assign fa_a    = running & a_sr[0];
  assign fa_b    = running & (b_sr[0] ^ sub_r);
  assign fa_cin  = running & carry_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      sub_r    <= 1'b0;
      carry_r  <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= op_a;
            b_sr    <= op_b;
            sub_r   <= sub;
            carry_r <= sub;
            cnt     <= '0;
            result  <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          result  <= {fa_sum, result[WIDTH-1:1]};
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry_r <= fa_carry;
          // Overflow is the carry into the MSB xor the carry out of it.
          if (cnt == CW'(WIDTH - 1)) begin
            cout     <= fa_carry;
            overflow <= carry_r ^ fa_carry;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
